cbus_arbiter_n: RTL



---
 rtl/cbus_pkg.sv | 25 ++
 rtl/cbus_arbiter_n.sv | 139 +++++++++++++
 2 files changed

// File: rtl/cbus_pkg.sv
// Cache-bus request/response types shared by the arbiter and its users.
package cbus_pkg;

    // Burst length encodings: the len field holds (beats - 1).
    localparam logic [7:0] MLEN1  = 8'd0;
    localparam logic [7:0] MLEN4  = 8'd3;
    localparam logic [7:0] MLEN8  = 8'd7;
    localparam logic [7:0] MLEN16 = 8'd15;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [7:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter_n.sv
// N-to-1 cache-bus arbiter. It grants one channel at a time (round-robin or
// fixed priority) and holds the grant until the downstream signals last.
// Each burst's beat count is checked against its len field, and a mismatch
// raises a sticky error flag that only reset clears.
module cbus_arbiter_n
    import cbus_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int FIXED_PRIO = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  cbus_req_t  [NUM_CH-1:0]           ireqs,
    output cbus_resp_t [NUM_CH-1:0]           iresps,
    output cbus_req_t                         oreq,
    input  cbus_resp_t                        oresp,
    output logic                              busy,
    output logic [$clog2(NUM_CH)-1:0]         owner,
    output logic                              len_err
);

    localparam int OW = $clog2(NUM_CH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          state_r,    state_s;
    logic [OW-1:0]   owner_r,    owner_s;
    logic [OW-1:0]   rr_ptr_r,   rr_ptr_s;
    logic [7:0]      beat_cnt_r, beat_cnt_s;
    logic            len_err_r,  len_err_s;

    logic            win_valid_s;
    logic [OW-1:0]   win_idx_s;

    // Channel index one above idx, wrapping at NUM_CH.
    function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] idx);
        logic [OW-1:0] res;
        if (int'(idx) >= NUM_CH - 1) begin
            res = '0;
        end else begin
            res = idx + OW'(1);
        end
        return res;
    endfunction

    // Pick the winner: scan upward from rr_ptr (or from 0 in fixed mode) with wrap.
    always_comb begin
        int            base_s;
        int            sum_s;
        logic [OW-1:0] pick_s;
        logic          hit_s;
        win_valid_s = 1'b0;
        win_idx_s   = '0;
        base_s      = (FIXED_PRIO != 0) ? 0 : int'(rr_ptr_r);
        for (int k = 0; k < NUM_CH; k++) begin
            sum_s       = base_s + k;
            pick_s      = OW'((sum_s >= NUM_CH) ? (sum_s - NUM_CH) : sum_s);
            hit_s       = !win_valid_s && ireqs[pick_s].valid;
            win_idx_s   = hit_s ? pick_s : win_idx_s;
            win_valid_s = win_valid_s | hit_s;
        end
    end

    // Next-state logic for the grant FSM, beat counter, pointer and error flag.
    always_comb begin
        state_s    = state_r;
        owner_s    = owner_r;
        rr_ptr_s   = rr_ptr_r;
        beat_cnt_s = beat_cnt_r;
        len_err_s  = len_err_r;
        case (state_r)
            ST_IDLE: begin
                if (win_valid_s) begin
                    state_s    = ST_BUSY;
                    owner_s    = win_idx_s;
                    beat_cnt_s = 8'd0;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Beats are counted on ready alone, even if the owner dropped valid.
                if (oresp.ready) begin
                    beat_cnt_s = beat_cnt_r + 8'd1;
                    if (oresp.last) begin
                        state_s   = ST_IDLE;
                        rr_ptr_s  = (FIXED_PRIO != 0) ? rr_ptr_r : next_idx(owner_r);
                        len_err_s = len_err_r | (beat_cnt_r != ireqs[owner_r].len);
                    end else begin
                        state_s   = ST_BUSY;
                    end
                end else begin
                    state_s = ST_BUSY;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers; reset drops everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            owner_r    <= '0;
            rr_ptr_r   <= '0;
            beat_cnt_r <= 8'd0;
            len_err_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            owner_r    <= owner_s;
            rr_ptr_r   <= rr_ptr_s;
            beat_cnt_r <= beat_cnt_s;
            len_err_r  <= len_err_s;
        end
    end

    // Zero-latency data path: route the owner's request down and the response back.
    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (state_r == ST_BUSY) begin
            oreq            = ireqs[owner_r];
            iresps[owner_r] = oresp;
        end else begin
            oreq   = '0;
            iresps = '0;
        end
    end

    assign busy    = (state_r == ST_BUSY);
    assign owner   = owner_r;
    assign len_err = len_err_r;

endmodule
